// File: rtl/instr_word_assembler.sv
// Collects MSP430/MSP430X opcode, prefix and extension words into one bundle per
// instruction and queues finished bundles in a small FIFO ahead of the decoder.
module instr_word_assembler #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned AW        = 16,
    parameter bit          PREFIX_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [15:0]   inWord,
    input  logic [AW-1:0] inAddr,
    input  logic          inValid,
    output logic          inReady,
    output logic          outValid,
    input  logic          outReady,
    output logic [15:0]   outOpcode,
    output logic [15:0]   outSrcExt,
    output logic [15:0]   outDstExt,
    output logic [15:0]   outPrefix,
    output logic          outHasPrefix,
    output logic [AW-1:0] outAddr,
    output logic [2:0]    outLen,
    output logic          outIllegal,
    output logic [3:0]    outSrcA,
    output logic [3:0]    outDstA,
    output logic [1:0]    outAs,
    output logic          outAd,
    output logic          outBW
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_OP, S_OP_PFX, S_SRC, S_DST} state_t;

    typedef struct packed {
        logic [15:0]   opcode;
        logic [15:0]   src_ext;
        logic [15:0]   dst_ext;
        logic [15:0]   prefix;
        logic          has_prefix;
        logic [AW-1:0] addr;
        logic [2:0]    len;
        logic          illegal;
        logic [3:0]    src_a;
        logic [3:0]    dst_a;
        logic [1:0]    as_mode;
        logic          ad;
        logic          bw;
    } bundle_t;

    // Fills the decoded operand fields from the opcode; a prefix word reaching
    // here as an opcode is never a legal class, so it always decodes illegal.
    function automatic bundle_t decode(input bundle_t b);
        bundle_t d;
        logic    fmt1;
        logic    fmt2;
        d         = b;
        fmt1      = b.opcode[15:12] >= 4'd4;
        fmt2      = (b.opcode[15:10] == 6'b000100) && (b.opcode[9:7] != 3'b111);
        d.illegal = !(fmt1 || fmt2 || (b.opcode[15:13] == 3'b001));
        d.src_a   = fmt1 ? b.opcode[11:8] : (fmt2 ? b.opcode[3:0] : 4'd0);
        d.dst_a   = fmt1 ? b.opcode[3:0] : 4'd0;
        d.as_mode = (fmt1 || fmt2) ? b.opcode[5:4] : 2'd0;
        d.ad      = fmt1 && b.opcode[7];
        d.bw      = (fmt1 || fmt2) && b.opcode[6];
        return d;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t        state;
    state_t        state_nx;
    logic [15:0]   op_reg;
    logic [15:0]   pfx_reg;
    logic [15:0]   src_reg;
    logic [AW-1:0] addr_reg;
    logic          has_pfx;
    logic          src_need;
    logic          dst_need;

    logic          w_fmt1;
    logic          w_fmt2;
    logic          w_pfx;
    logic          w_src;
    logic          w_dst;
    logic [3:0]    w_sreg;

    logic          accept;
    logic          pop;
    logic          push;
    bundle_t       raw;
    bundle_t       bundle;

    bundle_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    bundle_t       head;

    assign inReady = !flush && (count < CW'(DEPTH));
    assign accept  = inValid && inReady;
    assign pop     = (count != '0) && outReady && !flush;

    always_comb begin
        w_fmt1 = inWord[15:12] >= 4'd4;
        w_fmt2 = (inWord[15:10] == 6'b000100) && (inWord[9:7] != 3'b111);
        w_pfx  = PREFIX_EN && (inWord[15:11] == 5'b00011);
        w_sreg = w_fmt1 ? inWord[11:8] : inWord[3:0];
        // RETI (opcode[9:7] = 110) carries no source operand
        w_src  = (w_fmt1 || (w_fmt2 && (inWord[9:7] != 3'b110))) &&
                 (((inWord[5:4] == 2'b01) && (w_sreg != 4'd3)) ||
                  ((inWord[5:4] == 2'b11) && (w_sreg == 4'd0)));
        w_dst  = w_fmt1 && inWord[7];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= S_OP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                S_OP, S_OP_PFX: begin
                    if (w_pfx)      state_nx = (state == S_OP) ? S_OP_PFX : S_OP;
                    else if (w_src) state_nx = S_SRC;
                    else if (w_dst) state_nx = S_DST;
                    else            state_nx = S_OP;
                end
                S_SRC:   state_nx = dst_need ? S_DST : S_OP;
                default: state_nx = S_OP;
            endcase
        end
    end

    // Partial registers are all zero in S_OP, so one length formula serves every state.
    always_comb begin
        push           = 1'b0;
        raw            = '0;
        raw.opcode     = op_reg;
        raw.src_ext    = src_reg;
        raw.prefix     = pfx_reg;
        raw.has_prefix = has_pfx;
        raw.addr       = addr_reg;
        raw.len        = 3'd1 + {2'b00, has_pfx} + {2'b00, src_need} + {2'b00, dst_need};
        case (state)
            S_OP, S_OP_PFX: begin
                raw.opcode = inWord;
                if (state == S_OP) raw.addr = inAddr;
                push = accept && (w_pfx ? (state == S_OP_PFX) : (!w_src && !w_dst));
            end
            S_SRC: begin
                raw.src_ext = inWord;
                push        = accept && !dst_need;
            end
            default: begin
                raw.dst_ext = inWord;
                push        = accept;
            end
        endcase
        bundle = decode(raw);
    end

    always_ff @(posedge clk) begin
        if (rst || flush || push) begin
            op_reg   <= '0;
            pfx_reg  <= '0;
            src_reg  <= '0;
            addr_reg <= '0;
            has_pfx  <= 1'b0;
            src_need <= 1'b0;
            dst_need <= 1'b0;
        end else if (accept) begin
            case (state)
                S_OP, S_OP_PFX: begin
                    if (w_pfx) begin
                        pfx_reg  <= inWord;
                        has_pfx  <= 1'b1;
                        addr_reg <= inAddr;
                    end else begin
                        op_reg   <= inWord;
                        src_need <= w_src;
                        dst_need <= w_dst;
                        if (state == S_OP) addr_reg <= inAddr;
                    end
                end
                S_SRC:   src_reg <= inWord;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (push) begin
                mem[wr_ptr] <= bundle;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head         = mem[rd_ptr];
    assign outValid     = (count != '0);
    assign outOpcode    = head.opcode;
    assign outSrcExt    = head.src_ext;
    assign outDstExt    = head.dst_ext;
    assign outPrefix    = head.prefix;
    assign outHasPrefix = head.has_prefix;
    assign outAddr      = head.addr;
    assign outLen       = head.len;
    assign outIllegal   = head.illegal;
    assign outSrcA      = head.src_a;
    assign outDstA      = head.dst_a;
    assign outAs        = head.as_mode;
    assign outAd        = head.ad;
    assign outBW        = head.bw;

endmodule

// File: tb/tb_instr_word_assembler.sv
// Bench for instr_word_assembler: directed and random word streams checked against
// a word-list reference model of MSP430 instruction lengths and field extraction.
module tb_instr_word_assembler;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] inWord = '0;
    logic [15:0] inAddr = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [15:0] outOpcode, outSrcExt, outDstExt, outPrefix, outAddr;
    logic        outHasPrefix, outIllegal, outAd, outBW;
    logic [2:0]  outLen;
    logic [3:0]  outSrcA, outDstA;
    logic [1:0]  outAs;

    logic        np_flush = 1'b0;
    logic [15:0] np_inWord = '0;
    logic [15:0] np_inAddr = '0;
    logic        np_inValid = 1'b0;
    logic        np_inReady;
    logic        np_outValid;
    logic        np_outReady = 1'b1;
    logic [15:0] np_outOpcode, np_outSrcExt, np_outDstExt, np_outPrefix, np_outAddr;
    logic        np_outHasPrefix, np_outIllegal, np_outAd, np_outBW;
    logic [2:0]  np_outLen;
    logic [3:0]  np_outSrcA, np_outDstA;
    logic [1:0]  np_outAs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_word_assembler #(.DEPTH(DEPTH), .AW(16), .PREFIX_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .inWord(inWord), .inAddr(inAddr),
        .inValid(inValid), .inReady(inReady), .outValid(outValid), .outReady(outReady),
        .outOpcode(outOpcode), .outSrcExt(outSrcExt), .outDstExt(outDstExt),
        .outPrefix(outPrefix), .outHasPrefix(outHasPrefix), .outAddr(outAddr),
        .outLen(outLen), .outIllegal(outIllegal), .outSrcA(outSrcA), .outDstA(outDstA),
        .outAs(outAs), .outAd(outAd), .outBW(outBW)
    );

    instr_word_assembler #(.DEPTH(DEPTH), .AW(16), .PREFIX_EN(1'b0)) dut_np (
        .clk(clk), .rst(rst), .flush(np_flush), .inWord(np_inWord), .inAddr(np_inAddr),
        .inValid(np_inValid), .inReady(np_inReady), .outValid(np_outValid),
        .outReady(np_outReady), .outOpcode(np_outOpcode), .outSrcExt(np_outSrcExt),
        .outDstExt(np_outDstExt), .outPrefix(np_outPrefix), .outHasPrefix(np_outHasPrefix),
        .outAddr(np_outAddr), .outLen(np_outLen), .outIllegal(np_outIllegal),
        .outSrcA(np_outSrcA), .outDstA(np_outDstA), .outAs(np_outAs), .outAd(np_outAd),
        .outBW(np_outBW)
    );

    typedef struct {
        logic [15:0] opcode, src_ext, dst_ext, prefix, addr;
        logic        has_prefix, illegal, ad, bw;
        logic [2:0]  len;
        logic [3:0]  src_a, dst_a;
        logic [1:0]  as_mode;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] pend[$];
    logic [15:0] pend_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_pfx(input logic [15:0] w);
        return (w >= 16'h1800) && (w <= 16'h1FFF);
    endfunction

    function automatic int n_src(input logic [15:0] w);
        int as_m, r;
        as_m = int'((w >> 4) & 16'h3);
        if (w >= 16'h4000)                       r = int'((w >> 8) & 16'hF);
        else if (w >= 16'h1000 && w < 16'h1300)  r = int'(w & 16'hF);
        else                                     return 0;
        if (as_m == 1 && r != 3) return 1;
        if (as_m == 3 && r == 0) return 1;
        return 0;
    endfunction

    function automatic int n_dst(input logic [15:0] w);
        return (w >= 16'h4000 && w[7]) ? 1 : 0;
    endfunction

    // The model keeps the raw word list of the current instruction and emits
    // a bundle once the list is as long as the leading words say it must be.
    function automatic void model_word(input logic [15:0] w, input logic [15:0] a);
        int   oi, need;
        bit   f1, f2, jmp;
        exp_t e;
        logic [15:0] op;
        if (pend.size() == 0) pend_addr = a;
        pend.push_back(w);
        oi = is_pfx(pend[0]) ? 1 : 0;
        if (pend.size() <= oi) return;
        op   = pend[oi];
        need = 1 + oi + (is_pfx(op) ? 0 : n_src(op) + n_dst(op));
        if (pend.size() != need) return;
        f1  = op >= 16'h4000;
        f2  = op >= 16'h1000 && op < 16'h1380;
        jmp = op >= 16'h2000 && op < 16'h4000;
        e.opcode     = op;
        e.src_ext    = (n_src(op) != 0) ? pend[oi + 1] : 16'h0;
        e.dst_ext    = (n_dst(op) != 0) ? pend[need - 1] : 16'h0;
        e.prefix     = (oi != 0) ? pend[0] : 16'h0;
        e.has_prefix = (oi != 0);
        e.addr       = pend_addr;
        e.len        = 3'(need);
        e.illegal    = !(f1 || f2 || jmp);
        e.src_a      = f1 ? 4'((op >> 8) & 16'hF) : (f2 ? 4'(op & 16'hF) : 4'h0);
        e.dst_a      = f1 ? 4'(op & 16'hF) : 4'h0;
        e.as_mode    = (f1 || f2) ? 2'((op >> 4) & 16'h3) : 2'h0;
        e.ad         = f1 && op[7];
        e.bw         = (f1 || f2) && op[6];
        expq.push_back(e);
        pend.delete();
    endfunction

    task automatic check_head();
        exp_t e;
        e = expq[0];
        chk("opcode", outOpcode, e.opcode);
        chk("srcExt", outSrcExt, e.src_ext);
        chk("dstExt", outDstExt, e.dst_ext);
        chk("prefix", outPrefix, e.prefix);
        chk("hasPrefix", outHasPrefix, e.has_prefix);
        chk("addr", outAddr, e.addr);
        chk("len", outLen, e.len);
        chk("illegal", outIllegal, e.illegal);
        chk("srcA", outSrcA, e.src_a);
        chk("dstA", outDstA, e.dst_a);
        chk("as", outAs, e.as_mode);
        chk("ad", outAd, e.ad);
        chk("bw", outBW, e.bw);
    endtask

    task automatic cycle(input logic v, input logic [15:0] w, input logic [15:0] a,
                         input logic ordy, input logic fl, output bit acc);
        bit pp;
        @(negedge clk);
        inValid = v; inWord = w; inAddr = a; outReady = ordy; flush = fl;
        #1;
        chk("inReady", inReady, !fl && (expq.size() < DEPTH));
        chk("outValid", outValid, expq.size() != 0);
        if (expq.size() != 0) check_head();
        acc = v && !fl && (expq.size() < DEPTH);
        pp  = ordy && !fl && (expq.size() != 0);
        @(posedge clk);
        if (fl) begin
            pend.delete();
            expq.delete();
        end else begin
            if (pp) void'(expq.pop_front());
            if (acc) model_word(w, a);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic [15:0] a, input logic ordy);
        bit acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, w, a, ordy, 1'b0, acc);
            n++;
        end while (!acc && n < 40);
        n_cmp++;
        assert (acc)
        else begin
            n_err++;
            $error("FAIL send_timeout: observed %0d expected 1", acc);
        end
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        cycle(1'b0, 16'h0, 16'h0, ordy, 1'b0, acc);
        #1;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
            n++;
        end
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; inValid = 1'b0; flush = 1'b0; outReady = 1'b0;
        inWord = '0; inAddr = '0;
        @(posedge clk);
        #1;
        chk("rst_outValid", outValid, 0);
        chk("rst_opcode", outOpcode, 0);
        chk("rst_srcExt", outSrcExt, 0);
        chk("rst_dstExt", outDstExt, 0);
        chk("rst_prefix", outPrefix, 0);
        chk("rst_hasPrefix", outHasPrefix, 0);
        chk("rst_addr", outAddr, 0);
        chk("rst_len", outLen, 0);
        chk("rst_illegal", outIllegal, 0);
        chk("rst_fields", {outSrcA, outDstA, outAs, outAd, outBW}, 0);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        pend.delete();
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] r;
        case ($urandom_range(0, 7))
            0: return 16'h4000 + 16'($urandom_range(0, 16'hBFFF));
            1, 2: begin
                case ($urandom_range(0, 3))
                    0:       r = 4'd0;
                    1:       r = 4'd2;
                    2:       r = 4'd3;
                    default: r = 4'($urandom_range(0, 15));
                endcase
                return {4'($urandom_range(4, 15)), r, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15))};
            end
            3: return 16'h1000 + 16'($urandom_range(0, 16'h3FF));
            4: return 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
            5: return 16'h1800 + 16'($urandom_range(0, 16'h7FF));
            6: return 16'($urandom_range(0, 16'h17FF));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bit acc;

        do_reset();

        send_word(16'h4405, 16'hC000, 1'b0);
        idle(1'b0);
        chk("mov_len", outLen, 1);
        chk("mov_srcA", outSrcA, 4);
        chk("mov_dstA", outDstA, 5);
        chk("mov_as_ad_bw", {outAs, outAd, outBW}, 0);
        drain();

        send_word(16'h40B2, 16'hC000, 1'b0);
        send_word(16'h1234, 16'hC002, 1'b0);
        send_word(16'h0200, 16'hC004, 1'b0);
        idle(1'b0);
        chk("ind_len", outLen, 3);
        chk("ind_addr", outAddr, 16'hC000);
        chk("ind_srcExt", outSrcExt, 16'h1234);
        chk("ind_dstExt", outDstExt, 16'h0200);
        chk("ind_as", outAs, 3);
        chk("ind_srcA", outSrcA, 0);
        chk("ind_ad", outAd, 1);
        chk("ind_dstA", outDstA, 2);
        drain();

        send_word(16'h5225, 16'hC010, 1'b1);
        send_word(16'h5315, 16'hC012, 1'b1);
        send_word(16'h3C05, 16'hC014, 1'b1);
        send_word(16'h1300, 16'hC016, 1'b1);
        drain();

        send_word(16'h1230, 16'hC020, 1'b0);
        send_word(16'h00AA, 16'hC022, 1'b0);
        idle(1'b0);
        chk("push_len", outLen, 2);
        chk("push_srcExt", outSrcExt, 16'h00AA);
        drain();
        send_word(16'h0123, 16'hC024, 1'b0);
        idle(1'b0);
        chk("ill_illegal", outIllegal, 1);
        chk("ill_len", outLen, 1);
        drain();

        send_word(16'h1800, 16'hC030, 1'b0);
        send_word(16'h4405, 16'hC032, 1'b0);
        idle(1'b0);
        chk("pfx_len", outLen, 2);
        chk("pfx_has", outHasPrefix, 1);
        chk("pfx_word", outPrefix, 16'h1800);
        chk("pfx_addr", outAddr, 16'hC030);
        drain();
        send_word(16'h1900, 16'hC040, 1'b1);
        send_word(16'h1A00, 16'hC042, 1'b1);
        drain();

        send_word(16'h4405, 16'hD000, 1'b0);
        send_word(16'h4405, 16'hD002, 1'b0);
        cycle(1'b1, 16'h4405, 16'hD004, 1'b0, 1'b0, acc);
        chk("bp_inReady_full", inReady, 0);
        cycle(1'b1, 16'h4405, 16'hD004, 1'b0, 1'b0, acc);
        send_word(16'h4405, 16'hD004, 1'b1);
        drain();

        send_word(16'h40B2, 16'hE000, 1'b1);
        send_word(16'h1234, 16'hE002, 1'b1);
        cycle(1'b1, 16'h5555, 16'hE004, 1'b1, 1'b1, acc);
        send_word(16'h4405, 16'hE006, 1'b0);
        idle(1'b0);
        chk("flush_opcode", outOpcode, 16'h4405);
        chk("flush_len", outLen, 1);
        send_word(16'h4405, 16'hE008, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, acc);
        #1;
        chk("flush_empty", outValid, 0);
        drain();

        @(negedge clk);
        np_inValid = 1'b1; np_inWord = 16'h1800; np_inAddr = 16'h0200;
        @(negedge clk);
        np_inWord = 16'h4405; np_inAddr = 16'h0202;
        #1;
        chk("np_valid", np_outValid, 1);
        chk("np_opcode", np_outOpcode, 16'h1800);
        chk("np_illegal", np_outIllegal, 1);
        chk("np_len", np_outLen, 1);
        chk("np_has", np_outHasPrefix, 0);
        @(negedge clk);
        np_inValid = 1'b0;
        #1;
        chk("np_next_opcode", np_outOpcode, 16'h4405);
        chk("np_next_len", np_outLen, 1);
        chk("np_next_illegal", np_outIllegal, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle(1'($urandom_range(0, 3) != 0), rand_word(), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
